// File: rtl/tcp_misc_pkg.sv
// Shared TCP TX types: scheduler snapshot/command structs, per-flag command
// encoding and the flow/timestamp sizing constants.
package tcp_misc_pkg;

  localparam int MAX_FLOW_CNT = 8;
  localparam int FLOWID_W     = 3;
  localparam int SCHED_TS_W   = 8;

  // Flag slots in the scheduler's per-flow state.
  localparam int NUM_FLAGS = 3;
  localparam int FLAG_RT   = 0;
  localparam int FLAG_ACK  = 1;
  localparam int FLAG_DATA = 2;

  typedef enum logic [1:0] {
    FLAG_NOP   = 2'd0,
    FLAG_SET   = 2'd1,
    FLAG_CLEAR = 2'd2
  } flag_cmd_e;

  typedef struct packed {
    logic                  flag;
    logic [SCHED_TS_W-1:0] ts;
  } flag_state_t;

  typedef struct packed {
    logic [SCHED_TS_W-1:0] ts;
    flag_cmd_e             cmd;
  } flag_upd_t;

  typedef struct packed {
    logic [FLOWID_W-1:0] flowid;
    flag_state_t         rt;
    flag_state_t         ack_pend;
    flag_state_t         data_pend;
  } sched_data_struct;

  typedef struct packed {
    logic [FLOWID_W-1:0] flowid;
    flag_upd_t           rt;
    flag_upd_t           ack_pend;
    flag_upd_t           data_pend;
  } sched_cmd_struct;

endpackage

// File: rtl/rr_arbiter_ptr.sv
// Combinational round-robin search: first asserted request at or after the
// start pointer, wrapping modulo N (N must be a power of two).
module rr_arbiter_ptr #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = start + IDX_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/tcp_tx_flow_sched.sv
// Per-flow TX scheduler: versioned rt/ack/data pending flags, round-robin
// grant of one snapshot at a time, version-checked clears from the datapath.
module tcp_tx_flow_sched
  import tcp_misc_pkg::MAX_FLOW_CNT, tcp_misc_pkg::NUM_FLAGS, tcp_misc_pkg::FLAG_RT,
         tcp_misc_pkg::FLAG_ACK, tcp_misc_pkg::FLAG_DATA, tcp_misc_pkg::FLAG_SET,
         tcp_misc_pkg::FLAG_CLEAR, tcp_misc_pkg::flag_state_t, tcp_misc_pkg::flag_upd_t,
         tcp_misc_pkg::sched_data_struct, tcp_misc_pkg::sched_cmd_struct;
#(
  parameter int NUM_FLOWS  = MAX_FLOW_CNT,
  parameter int FLOWID_W   = tcp_misc_pkg::FLOWID_W,
  parameter int SCHED_TS_W = tcp_misc_pkg::SCHED_TS_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                app_sched_data_set_val,
  input  logic [FLOWID_W-1:0] app_sched_data_set_flowid,
  input  logic                rx_sched_ack_set_val,
  input  logic [FLOWID_W-1:0] rx_sched_ack_set_flowid,
  input  logic                timer_sched_rt_set_val,
  input  logic [FLOWID_W-1:0] timer_sched_rt_set_flowid,
  input  logic                tx_sched_update_val,
  input  sched_cmd_struct     tx_sched_update_cmd,
  output logic                sched_tx_req_val,
  input  logic                sched_tx_req_rdy,
  output sched_data_struct    sched_tx_req_data
);

  typedef enum logic {S_IDLE, S_HOLD} state_e;

  state_e               state_q, state_d;
  flag_state_t          flag_q [NUM_FLOWS][NUM_FLAGS];
  flag_state_t          flag_d [NUM_FLOWS][NUM_FLAGS];
  logic [NUM_FLOWS-1:0] in_flight_q, in_flight_d, eligible;
  logic [FLOWID_W-1:0]  rr_ptr_q, sel_idx;
  logic                 sel_found, grant;
  sched_data_struct     req_data_q;

  logic [NUM_FLAGS-1:0] set_val;
  logic [FLOWID_W-1:0]  set_id   [NUM_FLAGS];
  flag_upd_t            upd_flag [NUM_FLAGS];

  assign set_val[FLAG_RT]    = timer_sched_rt_set_val;
  assign set_val[FLAG_ACK]   = rx_sched_ack_set_val;
  assign set_val[FLAG_DATA]  = app_sched_data_set_val;
  assign set_id[FLAG_RT]     = timer_sched_rt_set_flowid;
  assign set_id[FLAG_ACK]    = rx_sched_ack_set_flowid;
  assign set_id[FLAG_DATA]   = app_sched_data_set_flowid;
  assign upd_flag[FLAG_RT]   = tx_sched_update_cmd.rt;
  assign upd_flag[FLAG_ACK]  = tx_sched_update_cmd.ack_pend;
  assign upd_flag[FLAG_DATA] = tx_sched_update_cmd.data_pend;

  always_comb begin
    eligible = '0;
    for (int f = 0; f < NUM_FLOWS; f++) begin
      for (int k = 0; k < NUM_FLAGS; k++) eligible[f] = eligible[f] | flag_q[f][k].flag;
      eligible[f] = eligible[f] & ~in_flight_q[f];
    end
  end

  rr_arbiter_ptr #(.N(NUM_FLOWS), .IDX_W(FLOWID_W)) u_arb (
    .req   (eligible),
    .start (rr_ptr_q),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // A set (port or update SET) beats a same-cycle CLEAR and bumps the version,
  // so any CLEAR built from an older snapshot can no longer match.
  always_comb begin
    logic upd_hit, set_hit, clr_hit;
    flag_d      = flag_q;
    in_flight_d = in_flight_q;
    upd_hit     = 1'b0;
    set_hit     = 1'b0;
    clr_hit     = 1'b0;
    for (int f = 0; f < NUM_FLOWS; f++) begin
      upd_hit = tx_sched_update_val && (tx_sched_update_cmd.flowid == FLOWID_W'(f));
      for (int k = 0; k < NUM_FLAGS; k++) begin
        set_hit = (set_val[k] && (set_id[k] == FLOWID_W'(f))) ||
                  (upd_hit && (upd_flag[k].cmd == FLAG_SET));
        clr_hit = upd_hit && (upd_flag[k].cmd == FLAG_CLEAR) &&
                  (upd_flag[k].ts == flag_q[f][k].ts);
        if (set_hit) begin
          flag_d[f][k].flag = 1'b1;
          flag_d[f][k].ts   = flag_q[f][k].ts + SCHED_TS_W'(1);
        end else if (clr_hit) begin
          flag_d[f][k].flag = 1'b0;
        end
      end
      if (upd_hit) in_flight_d[f] = 1'b0;
      if (grant && (sel_idx == FLOWID_W'(f))) in_flight_d[f] = 1'b1;
    end
  end

  // No reload out of HOLD in the accepting cycle: at most one grant per 2 cycles.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      S_IDLE: if (sel_found) begin
        grant   = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD:  if (sched_tx_req_rdy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      in_flight_q <= '0;
      req_data_q  <= '0;
      // NOTE: the flag array is small flop storage, not RAM, so it is reset with
      // everything else; a RAM-mapped array would be left unreset.
      for (int f = 0; f < NUM_FLOWS; f++)
        for (int k = 0; k < NUM_FLAGS; k++) flag_q[f][k] <= '0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= in_flight_d;
      for (int f = 0; f < NUM_FLOWS; f++)
        for (int k = 0; k < NUM_FLAGS; k++) flag_q[f][k] <= flag_d[f][k];
      if (grant) begin
        rr_ptr_q             <= sel_idx + FLOWID_W'(1);
        req_data_q.flowid    <= sel_idx;
        req_data_q.rt        <= flag_q[sel_idx][FLAG_RT];
        req_data_q.ack_pend  <= flag_q[sel_idx][FLAG_ACK];
        req_data_q.data_pend <= flag_q[sel_idx][FLAG_DATA];
      end
    end
  end

  assign sched_tx_req_val  = (state_q == S_HOLD);
  assign sched_tx_req_data = req_data_q;

endmodule
